// File: rtl/br_flow_deserializer_multichannel.sv
// ============================================================================
// Module   : br_flow_deserializer_multichannel
// Purpose  : Per-channel narrow-to-wide flit assembly with round-robin drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_flow_deserializer_multichannel #(
  parameter int NumChannels                     = 2,
  parameter int PushWidth                       = 8,
  parameter int PopWidth                        = 32,
  parameter int MetadataWidth                   = 1,
  parameter bit DeserializeMostSignificantFirst = 1'b1,
  parameter bit EnableAssertFinalNotValid       = 1'b1,
  localparam int RATIO     = PopWidth / PushWidth,
  localparam int CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1,
  localparam int CH_WIDTH  = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     push_ready,
  input  logic                     push_valid,
  input  logic [CH_WIDTH-1:0]      push_channel,
  input  logic [PushWidth-1:0]     push_data,
  input  logic                     push_last,
  input  logic [MetadataWidth-1:0] push_metadata,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [CH_WIDTH-1:0]      pop_channel,
  output logic [PopWidth-1:0]      pop_data,
  output logic                     pop_last,
  output logic [CNT_WIDTH-1:0]     pop_last_dont_care_count,
  output logic [MetadataWidth-1:0] pop_metadata
);

  logic [CNT_WIDTH-1:0]     cnt_q       [NumChannels];
  logic [CNT_WIDTH-1:0]     cnt_d       [NumChannels];
  logic [PopWidth-1:0]      asm_q       [NumChannels];
  logic [PopWidth-1:0]      asm_d       [NumChannels];
  logic [MetadataWidth-1:0] meta_q      [NumChannels];
  logic [MetadataWidth-1:0] meta_d      [NumChannels];
  logic [NumChannels-1:0]   slot_valid_q, slot_valid_d;
  logic [PopWidth-1:0]      slot_data_q [NumChannels];
  logic [PopWidth-1:0]      slot_data_d [NumChannels];
  logic                     slot_last_q [NumChannels];
  logic                     slot_last_d [NumChannels];
  logic [CNT_WIDTH-1:0]     slot_dc_q   [NumChannels];
  logic [CNT_WIDTH-1:0]     slot_dc_d   [NumChannels];
  logic [MetadataWidth-1:0] slot_meta_q [NumChannels];
  logic [MetadataWidth-1:0] slot_meta_d [NumChannels];
  logic [CH_WIDTH-1:0]      ptr_q, ptr_d;
  logic                     lock_q, lock_d;
  logic [CH_WIDTH-1:0]      lock_gnt_q, lock_gnt_d;

  logic [CNT_WIDTH-1:0]     w_cnt;
  logic [CNT_WIDTH-1:0]     w_pos;
  logic                     w_is_final;
  logic [PopWidth-1:0]      w_merged;
  logic [MetadataWidth-1:0] w_meta;
  logic [CH_WIDTH-1:0]      w_idx;
  logic [CH_WIDTH-1:0]      w_rr_gnt;
  logic                     w_found;
  logic [CH_WIDTH-1:0]      w_gnt;
  logic                     w_pop_fire;
  logic                     w_push_fire;

  // Round-robin pick; a stalled grant stays locked so the pop outputs hold.
  always_comb begin
    w_rr_gnt = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_idx = CH_WIDTH'((int'(ptr_q) + i) % NumChannels);
      if (!w_found && slot_valid_q[w_idx]) begin
        w_found  = 1'b1;
        w_rr_gnt = w_idx;
      end
    end
    w_gnt = lock_q ? lock_gnt_q : w_rr_gnt;
  end

  assign pop_valid                = |slot_valid_q;
  assign pop_channel              = w_gnt;
  assign pop_data                 = slot_data_q[w_gnt];
  assign pop_last                 = slot_last_q[w_gnt];
  assign pop_last_dont_care_count = slot_dc_q[w_gnt];
  assign pop_metadata             = slot_meta_q[w_gnt];
  assign w_pop_fire               = pop_valid && pop_ready;
  assign w_push_fire              = push_valid && push_ready;

  // Assembly of the addressed channel; untouched slots of asm stay zero.
  always_comb begin
    w_cnt      = cnt_q[push_channel];
    w_is_final = push_last || (w_cnt == CNT_WIDTH'(RATIO - 1));
    w_pos      = DeserializeMostSignificantFirst ? (CNT_WIDTH'(RATIO - 1) - w_cnt) : w_cnt;
    w_merged   = asm_q[push_channel];
    for (int k = 0; k < RATIO; k++) begin
      if (w_pos == CNT_WIDTH'(k)) w_merged[k*PushWidth +: PushWidth] = push_data;
    end
    w_meta     = (w_cnt == '0) ? push_metadata : meta_q[push_channel];
    push_ready = !rst && !(w_is_final && slot_valid_q[push_channel] &&
                           !(w_pop_fire && (w_gnt == push_channel)));
  end

  always_comb begin
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    meta_d       = meta_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    slot_last_d  = slot_last_q;
    slot_dc_d    = slot_dc_q;
    slot_meta_d  = slot_meta_q;
    ptr_d        = ptr_q;
    lock_d       = pop_valid && !pop_ready;
    lock_gnt_d   = w_gnt;

    if (w_pop_fire) begin
      slot_valid_d[w_gnt] = 1'b0;
      ptr_d = (w_gnt == CH_WIDTH'(NumChannels - 1)) ? '0 : w_gnt + CH_WIDTH'(1);
    end

    // Refill is applied after the pop clear so a same-cycle refill wins.
    if (w_push_fire) begin
      meta_d[push_channel] = w_meta;
      if (w_is_final) begin
        slot_valid_d[push_channel] = 1'b1;
        slot_data_d[push_channel]  = w_merged;
        slot_last_d[push_channel]  = push_last;
        slot_dc_d[push_channel]    = CNT_WIDTH'(RATIO - 1) - w_cnt;
        slot_meta_d[push_channel]  = w_meta;
        cnt_d[push_channel]        = '0;
        asm_d[push_channel]        = '0;
      end else begin
        asm_d[push_channel] = w_merged;
        cnt_d[push_channel] = w_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NumChannels; c++) begin
        cnt_q[c]       <= '0;
        asm_q[c]       <= '0;
        meta_q[c]      <= '0;
        slot_data_q[c] <= '0;
        slot_last_q[c] <= 1'b0;
        slot_dc_q[c]   <= '0;
        slot_meta_q[c] <= '0;
      end
      slot_valid_q <= '0;
      ptr_q        <= '0;
      lock_q       <= 1'b0;
      lock_gnt_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      meta_q       <= meta_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_last_q  <= slot_last_d;
      slot_dc_q    <= slot_dc_d;
      slot_meta_q  <= slot_meta_d;
      ptr_q        <= ptr_d;
      lock_q       <= lock_d;
      lock_gnt_q   <= lock_gnt_d;
    end
  end

`ifndef SYNTHESIS
  a_channel_range: assert property (@(posedge clk) disable iff (rst)
    push_valid |-> (int'(push_channel) < NumChannels));
  a_push_stable: assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> (push_valid && $stable(push_channel) &&
      $stable(push_data) && $stable(push_last) && $stable(push_metadata)));
  a_dont_care_zero: assert property (@(posedge clk) disable iff (rst)
    (pop_valid && !pop_last) |-> (pop_last_dont_care_count == '0));
  final begin
    if (EnableAssertFinalNotValid) assert (!pop_valid);
  end
`endif

endmodule

`default_nettype wire
